// File: rtl/irq_pending_ctrl.sv
// irq_pending_ctrl
// -----------------------------------------------------------------------------
// Upstream stage of the 4-bit priority encoder. Raw interrupt lines are
// synchronised, their rising edges are latched into a pending vector, and the
// masked pending vector is handed to an external encoder. The encoder's answer
// (index + valid) comes back in and drives a request/acknowledge handshake
// toward the consumer. Repeated edges on a channel that is already pending are
// recorded in sticky overflow flags.
//
// Ports:
//   clk        in   1  single clock, rising edge
//   rst        in   1  asynchronous active-high reset
//   irq_in     in   4  raw interrupt lines (asynchronous to clk)
//   mask       in   4  per-channel enables, 1 = enabled
//   pend       out  4  pending & mask, feeds the encoder input
//   enc_out    in   2  encoder index of the highest set bit of pend
//   enc_valid  in   1  encoder flag, 1 = pend nonzero
//   irq_req    out  1  request to the consumer
//   irq_id     out  2  channel being requested
//   irq_ack    in   1  consumer acknowledge, only looked at while requesting
//   ovf        out  4  sticky per-channel overflow flags
//   ovf_clr    in   1  synchronous clear of all overflow flags
// -----------------------------------------------------------------------------
module irq_pending_ctrl #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] irq_in,
    input  logic [3:0] mask,
    output logic [3:0] pend,
    input  logic [1:0] enc_out,
    input  logic       enc_valid,
    output logic       irq_req,
    output logic [1:0] irq_id,
    input  logic       irq_ack,
    output logic [3:0] ovf,
    input  logic       ovf_clr
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        HOLD = 2'b10
    } state_t;

    state_t     state;
    logic [3:0] sync_q [SYNC_STAGES];
    logic [3:0] sync_prev;
    logic [3:0] pending;
    logic [3:0] edge_det;
    logic [3:0] clr_vec;

    // Synchroniser chain plus one extra register holding the previous value of
    // the last stage, so a rising edge can be spotted. Because everything
    // resets to 0, a line that is already high when reset releases is seen as
    // a fresh edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            sync_prev <= '0;
        end else begin
            sync_q[0] <= irq_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            sync_prev <= sync_q[SYNC_STAGES-1];
        end
    end

    // Edge detection and the clear request coming from an acknowledged
    // handshake. The clear targets the captured irq_id, not whatever the
    // encoder currently reports, so masking during REQ still clears the
    // channel that was actually requested.
    always_comb begin
        edge_det = sync_q[SYNC_STAGES-1] & ~sync_prev;
        clr_vec  = '0;
        if (state == REQ && irq_ack) begin
            clr_vec[irq_id] = 1'b1;
        end
    end

    // Pending and overflow bookkeeping. A new edge always wins over a clear in
    // the same cycle; it only counts as an overflow when the bit was pending
    // and is not being consumed right now. A fresh overflow also wins over
    // ovf_clr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
            ovf     <= '0;
        end else begin
            pending <= (pending & ~clr_vec) | edge_det;
            ovf     <= (ovf_clr ? 4'b0000 : ovf) | (edge_det & pending & ~clr_vec);
        end
    end

    // Masking only hides pending bits from the encoder; it never clears them.
    assign pend = pending & mask;

    // Handshake FSM. irq_id is captured on leaving IDLE and then frozen until
    // the ack, and the HOLD cycle gives the external encoder time to see the
    // cleared pending bit before the next decision is taken in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            irq_req <= 1'b0;
            irq_id  <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (enc_valid) begin
                        irq_id  <= enc_out;
                        irq_req <= 1'b1;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    if (irq_ack) begin
                        irq_req <= 1'b0;
                        state   <= HOLD;
                    end
                end
                HOLD: begin
                    irq_req <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    irq_req <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule
